// File: rtl/score_pkg.sv
// score_pkg: state encoding, widths and seven-segment digit codes shared by score logic and display
package score_pkg;
  localparam int SCORE_W = 7;
  localparam int BCD_W = 4;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PLAY = 2'd1, ST_OVER = 2'd2} state_t;
  localparam logic [6:0] SEG_CODE [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
endpackage

// File: rtl/bcd_sat_adder.sv
// bcd_sat_adder: adds POINTS to binary and BCD score in parallel, saturating at MAX_SCORE
module bcd_sat_adder
  import score_pkg::*;
#(
  parameter int POINTS = 1,
  parameter int MAX_SCORE = 99
) (
  input  logic [BCD_W-1:0]   tens,
  input  logic [BCD_W-1:0]   units,
  input  logic [SCORE_W-1:0] score,
  output logic [BCD_W-1:0]   next_tens,
  output logic [BCD_W-1:0]   next_units,
  output logic [SCORE_W-1:0] next_score,
  output logic               sat
);
  localparam logic [7:0] PTS = 8'(POINTS);
  localparam logic [7:0] MAX8 = 8'(MAX_SCORE);
  localparam logic [BCD_W-1:0] MAX_T = BCD_W'(MAX_SCORE / 10);
  localparam logic [BCD_W-1:0] MAX_U = BCD_W'(MAX_SCORE % 10);
  logic [7:0] sum;
  logic [4:0] usum;
  logic carry;
  always_comb begin
    sum = {1'b0, score} + PTS;
    usum = {1'b0, units} + 5'(POINTS);
    carry = usum > 5'd9;
    sat = sum >= MAX8;
    next_score = sat ? SCORE_W'(MAX_SCORE) : sum[SCORE_W-1:0];
    next_units = sat ? MAX_U : (carry ? 4'(usum - 5'd10) : usum[3:0]);
    next_tens = sat ? MAX_T : tens + {3'b0, carry};
  end
endmodule

// File: rtl/score_keeper.sv
// score_keeper: saturating goal score with BCD digits and game state; high score built with SCORE_KEEPER_HIGH_SCORE_EN
module score_keeper
  import score_pkg::*;
#(
  parameter int MAX_SCORE = 99,
  parameter int POINTS = 1
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic               i_Start,
  input  logic               i_Goal,
  input  logic               i_Game_Over,
  output logic [SCORE_W-1:0] o_Score,
  output logic [BCD_W-1:0]   o_Tens,
  output logic [BCD_W-1:0]   o_Units,
  output logic [SCORE_W-1:0] o_High_Score,
  output logic               o_New_High,
  output logic               o_Max,
  output logic               o_Playing
);
  state_t state;
  logic goal_q, sat;
  logic [BCD_W-1:0] next_tens, next_units;
  logic [SCORE_W-1:0] next_score;
  bcd_sat_adder #(.POINTS(POINTS), .MAX_SCORE(MAX_SCORE)) adder (
    .tens(o_Tens), .units(o_Units), .score(o_Score),
    .next_tens(next_tens), .next_units(next_units), .next_score(next_score), .sat(sat)
  );
  // goal_q tracks i_Goal in every state so a goal held across game start never scores
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state <= ST_IDLE;
      goal_q <= 1'b0;
      o_Score <= '0;
      o_Tens <= '0;
      o_Units <= '0;
      o_Max <= 1'b0;
      o_Playing <= 1'b0;
    end else begin
      goal_q <= i_Goal;
      if (state == ST_PLAY) begin
        if (i_Game_Over) begin
          state <= ST_OVER;
          o_Playing <= 1'b0;
        end else if (i_Goal && !goal_q) begin
          o_Score <= next_score;
          o_Tens <= next_tens;
          o_Units <= next_units;
          o_Max <= sat;
        end
      end else if (i_Start) begin
        state <= ST_PLAY;
        o_Playing <= 1'b1;
        o_Score <= '0;
        o_Tens <= '0;
        o_Units <= '0;
        o_Max <= 1'b0;
      end
    end
  end
`ifdef SCORE_KEEPER_HIGH_SCORE_EN
  logic beat;
  assign beat = state == ST_PLAY && i_Game_Over && o_Score > o_High_Score;
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      o_High_Score <= '0;
      o_New_High <= 1'b0;
    end else begin
      o_New_High <= beat;
      if (beat) o_High_Score <= o_Score;
    end
  end
`else
  assign o_High_Score = '0;
  assign o_New_High = 1'b0;
`endif
endmodule

// File: doc/score_keeper.md
# score_keeper

Game score register between the frog movement logic and the two-digit seven-segment driver. Turns goal-reached events into a saturating 0–99 score, kept in binary and BCD. Also tracks a session high score and game state (idle / playing / over). Its binary score output feeds the segment display's score input directly. Its BCD outputs let later display logic drop the iterative divide-by-ten.

## Interface
- MAX_SCORE, 99: saturation ceiling; legal range 9..99
- POINTS, 1: points added per goal event; legal range 1..9
- i_Clk  in  1  system clock (25 MHz pixel clock domain)
- i_Reset  in  1  asynchronous, active-high reset
- i_Start  in  1  level; starts a new game from IDLE or OVER
- i_Goal  in  1  level from frog movement; high while frog sits in goal row, may stay high many cycles
- i_Game_Over  in  1  single-cycle pulse; frog died or timer expired
- o_Score  out  7  binary score 0..MAX_SCORE
- o_Tens  out  4  BCD tens digit of o_Score
- o_Units  out  4  BCD units digit of o_Score
- o_High_Score  out  7  best score since reset, binary
- o_New_High  out  1  one-cycle pulse when o_High_Score increases
- o_Max  out  1  high while o_Score == MAX_SCORE
- o_Playing  out  1  high in PLAY state

## Operation
- Reset values: o_Score 0, o_Tens 0, o_Units 0, o_High_Score 0, o_New_High 0, o_Max 0, o_Playing 0, state IDLE, goal-edge register 0.
- States:
  - IDLE: score frozen. i_Start goes to PLAY and clears the score.
  - PLAY: goal events count. i_Game_Over goes to OVER.
  - OVER: score frozen and shown. i_Start goes to PLAY and clears the score to 0.
- i_Start in PLAY is ignored.
- Goal event: rising edge of i_Goal, detected against a registered copy of i_Goal. Holding i_Goal high scores exactly once. i_Goal already high when PLAY is entered does not score until it falls and rises again.
- Scoring adds POINTS, saturating at MAX_SCORE (never wraps). Events at MAX_SCORE are absorbed with no change.
- Scoring arithmetic:
  - Binary add is done 8 bits wide, compared against MAX_SCORE, then truncated to 7 bits.
  - The BCD digits are updated by a parallel BCD add with a units carry (units+POINTS > 9 gives units−10 and tens+1).
  - On saturation the BCD digits are loaded with the constant BCD form of MAX_SCORE.
  - The BCD digits are never recomputed from the binary score.
- Simultaneous events:
  - i_Game_Over and a goal edge in the same cycle: game over wins and the point is dropped.
  - i_Start and i_Game_Over in the same cycle in PLAY: go to OVER.
- High score: on the transition into OVER, if o_Score > o_High_Score, load it and pulse o_New_High for one cycle. Equal scores do not pulse.
- Asynchronous reset mid-game returns everything, including the high score, to reset values immediately.

## Timing
- Goal edge sampled at clock edge n (i_Goal high, registered copy low): o_Score, o_Tens, o_Units and o_Max update at edge n, so they are visible the cycle after i_Goal first reads high.
- i_Game_Over sampled at edge n: state is OVER, o_Playing low, o_High_Score and o_New_High updated, all at edge n. o_New_High falls at edge n+1.
- i_Start sampled at edge n: o_Playing high and score 0 at edge n.
- Minimum goal event rate: one per two cycles (high then low).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SCORE_KEEPER_HIGH_SCORE_EN defined: high-score register, compare logic and o_New_High are built as described above.
- SCORE_KEEPER_HIGH_SCORE_EN not defined: o_High_Score is tied to 0, o_New_High is tied to 0, and no compare logic is built. All other behaviour is unchanged.

## Structure
- Shared package score_pkg holds:
  - state encoding constants ST_IDLE, ST_PLAY, ST_OVER (2 bits)
  - SCORE_W = 7 and BCD_W = 4
  - seven-segment digit codes, moved here so the display driver shares them
- One sub-module, bcd_sat_adder:
  - takes current tens/units, binary score, POINTS and MAX_SCORE
  - returns next tens/units, next binary score and a saturate flag
  - purely combinational; its registers stay in score_keeper

## Test plan
- Reset, then i_Start, then 12 goal edges (each 3 cycles high, 2 low) -> o_Score 12, o_Tens 1, o_Units 2; o_Score updates one cycle after each rise.
- i_Goal held high 50 cycles in PLAY -> o_Score rises by exactly 1.
- POINTS=7 with score at 95 -> goal edge gives o_Score 99, o_Tens 9, o_Units 9, o_Max 1; further edges leave it unchanged.
- Score 23, then i_Game_Over -> OVER, o_High_Score 23, o_New_High one-cycle pulse. Next game ends at 23 -> no pulse. Next game ends at 40 -> o_High_Score 40 with a pulse.
- i_Game_Over and a goal edge in the same cycle at score 5 -> o_Score stays 5 and state is OVER. Goal edges in OVER -> no change.
- i_Reset asserted mid-cycle in PLAY at score 37, high 60 -> all outputs 0 before the next clock edge. Rebuild without the macro -> o_High_Score and o_New_High stay 0 throughout.
